// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with valid/ready input and a one-word holding buffer for gapless frames.
// States: IDLE = line idle | START = start bit | DATA = data bits LSB first | STOP = stop bit.
module uart_transmitter #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int WIDTH     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataIn,
  input  logic             dataValid,
  output logic             dataReady,
  output logic             uartTx,
  output logic             txBusy
);

  localparam int BAUD_COUNT = CLK_FREQ / BAUD_RATE;
  localparam int BAUD_W     = (BAUD_COUNT > 2) ? $clog2(BAUD_COUNT) : 1;

  generate
    if (BAUD_COUNT < 2) begin : gBaudCheck
      $error("uart_transmitter: CLK_FREQ / BAUD_RATE must be at least 2");
    end
    if (WIDTH < 5 || WIDTH > 9) begin : gWidthCheck
      $error("uart_transmitter: WIDTH must be in 5..9");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} stateType;

  stateType          state, stateNext;
  logic [WIDTH-1:0]  shiftReg, shiftNext;
  logic [WIDTH-1:0]  bufReg, bufNext;
  logic              bufFull, bufFullNext;
  logic [BAUD_W-1:0] baudCnt, baudNext;
  logic [3:0]        bitCnt, bitNext;
  logic              txNext, busyNext;
  logic              transfer, bitEnd;

  assign dataReady = !bufFull && !reset;
  assign transfer  = dataValid && dataReady;
  assign bitEnd    = (baudCnt == BAUD_W'(BAUD_COUNT - 1));

  always_comb begin
    stateNext   = state;
    shiftNext   = shiftReg;
    bufNext     = bufReg;
    bufFullNext = bufFull;
    baudNext    = (state == IDLE || bitEnd) ? '0 : baudCnt + BAUD_W'(1);
    bitNext     = bitCnt;
    txNext      = uartTx;

    case (state)
      IDLE: begin
        if (transfer) begin
          shiftNext = dataIn;
          stateNext = START;
          txNext    = 1'b0;
        end
      end
      START: begin
        if (bitEnd) begin
          stateNext = DATA;
          bitNext   = 4'd0;
          txNext    = shiftReg[0];
        end
      end
      DATA: begin
        if (bitEnd) begin
          shiftNext = shiftReg >> 1;
          bitNext   = bitCnt + 4'd1;
          if (bitCnt == 4'(WIDTH - 1)) begin
            stateNext = STOP;
            txNext    = 1'b1;
          end else begin
            txNext = shiftReg[1];
          end
        end
      end
      STOP: begin
        if (bitEnd) begin
          // Buffered word wins; otherwise a same-cycle handshake starts the next frame directly.
          if (bufFull) begin
            shiftNext   = bufReg;
            bufFullNext = 1'b0;
            stateNext   = START;
            txNext      = 1'b0;
          end else if (transfer) begin
            shiftNext = dataIn;
            stateNext = START;
            txNext    = 1'b0;
          end else begin
            stateNext = IDLE;
            txNext    = 1'b1;
          end
        end
      end
      default: begin
        stateNext = IDLE;
        txNext    = 1'b1;
      end
    endcase

    if (state != IDLE && transfer && !(state == STOP && bitEnd)) begin
      bufNext     = dataIn;
      bufFullNext = 1'b1;
    end

    busyNext = (stateNext != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      shiftReg <= '0;
      bufReg   <= '0;
      bufFull  <= 1'b0;
      baudCnt  <= '0;
      bitCnt   <= '0;
      uartTx   <= 1'b1;
      txBusy   <= 1'b0;
    end else begin
      state    <= stateNext;
      shiftReg <= shiftNext;
      bufReg   <= bufNext;
      bufFull  <= bufFullNext;
      baudCnt  <= baudNext;
      bitCnt   <= bitNext;
      uartTx   <= txNext;
      txBusy   <= busyNext;
    end
  end

endmodule
